// File: rtl/contador_push_param.sv
// Push-button up/down counter: edge-stepped, load with clamp, wrap or saturate, one-cycle limit pulse.
// Latency 1 edge (DB_CYCLES+1 with COUNTER_DEBOUNCE_EN); no backpressure, one step per input rising edge.
module contador_push_param #(
    parameter int WIDTH     = 2,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter bit SATURATE  = 1'b0,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_up,
    input  logic             push_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             limit
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic up_lvl;
    logic down_lvl;

`ifdef COUNTER_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]         raw;
    logic [1:0]         filt;
    logic [1:0][CW-1:0] stab;

    assign raw = {push_down, push_up};

    // Filtered level flips only after DB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            stab <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    stab[i] <= '0;
                end else if (stab[i] == DB_LAST) begin
                    filt[i] <= raw[i];
                    stab[i] <= '0;
                end else begin
                    stab[i] <= stab[i] + 1'b1;
                end
            end
        end
    end

    assign up_lvl   = filt[0];
    assign down_lvl = filt[1];
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign up_lvl    = push_up;
    assign down_lvl  = push_down;
`endif

    // Previous-value flops reset high so a button held through reset is not a press.
    logic prev_up;
    logic prev_down;
    logic up_edge;
    logic down_edge;

    assign up_edge   = up_lvl & ~prev_up;
    assign down_edge = down_lvl & ~prev_down;

    logic [WIDTH-1:0] next_count;
    logic             next_limit;

    always_comb begin
        next_count = count;
        next_limit = 1'b0;
        if (load) begin
            next_count = (load_value > MAX_C) ? MAX_C : load_value;
        end else if (up_edge && down_edge) begin
            next_count = count;
        end else if (up_edge) begin
            if (count == MAX_C) begin
                next_limit = 1'b1;
                next_count = SATURATE ? count : '0;
            end else begin
                next_count = count + 1'b1;
            end
        end else if (down_edge) begin
            if (count == '0) begin
                next_limit = 1'b1;
                next_count = SATURATE ? count : MAX_C;
            end else begin
                next_count = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up   <= 1'b1;
            prev_down <= 1'b1;
            count     <= '0;
            limit     <= 1'b0;
        end else begin
            prev_up   <= up_lvl;
            prev_down <= down_lvl;
            count     <= next_count;
            limit     <= next_limit;
        end
    end
endmodule

// File: tb/tb_contador_push_param.sv
// Bench for contador_push_param: a wrapping 2-bit instance and a saturating mod-10 4-bit instance share stimulus.
module tb_contador_push_param;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_up = 1'b0;
    logic       push_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;
    logic [1:0] count0;
    logic       limit0;
    logic [3:0] count1;
    logic       limit1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_push_param #(.WIDTH(2), .MAX_COUNT(3), .SATURATE(1'b0), .DB_CYCLES(DB)) d0 (
        .clk(clk), .rst_n(rst_n), .push_up(push_up), .push_down(push_down),
        .load(load), .load_value(lv[1:0]), .count(count0), .limit(limit0)
    );

    contador_push_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1), .DB_CYCLES(DB)) d1 (
        .clk(clk), .rst_n(rst_n), .push_up(push_up), .push_down(push_down),
        .load(load), .load_value(lv), .count(count1), .limit(limit1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-instance count and limit, shared press detection (channel 0 = up, 1 = down).
    int maxc [2] = '{3, 9};
    bit sat  [2] = '{1'b0, 1'b1};
    int m_cnt [2];
    bit m_lim [2];
    bit m_prev [2];
    bit m_filt [2];
    bit hist [2][$];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c]  = 0;
            m_lim[c]  = 1'b0;
            m_prev[c] = 1'b1;
            m_filt[c] = 1'b0;
            hist[c].delete();
        end
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        bit raw [2];
        bit lvl [2];
        bit edg [2];
        bit same;
        int lvk;
        if (!rst_n) begin
            model_reset();
        end else begin
            raw[0] = push_up;
            raw[1] = push_down;
            for (int c = 0; c < 2; c++) begin
`ifdef COUNTER_DEBOUNCE_EN
                lvl[c] = m_filt[c];
                hist[c].push_back(raw[c]);
                if (hist[c].size() > DB) void'(hist[c].pop_front());
                if (hist[c].size() == DB && raw[c] != m_filt[c]) begin
                    same = 1'b1;
                    foreach (hist[c][j]) if (hist[c][j] != raw[c]) same = 1'b0;
                    if (same) m_filt[c] = raw[c];
                end
`else
                same   = 1'b0;
                lvl[c] = raw[c];
`endif
                edg[c]    = lvl[c] && !m_prev[c];
                m_prev[c] = lvl[c];
            end
            for (int k = 0; k < 2; k++) begin
                lvk = (k == 0) ? int'(lv & 4'd3) : int'(lv);
                m_lim[k] = 1'b0;
                if (load) begin
                    m_cnt[k] = (lvk > maxc[k]) ? maxc[k] : lvk;
                end else if (edg[0] && edg[1]) begin
                    m_lim[k] = 1'b0;
                end else if (edg[0]) begin
                    if (m_cnt[k] == maxc[k]) begin
                        m_lim[k] = 1'b1;
                        if (!sat[k]) m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else if (edg[1]) begin
                    if (m_cnt[k] == 0) begin
                        m_lim[k] = 1'b1;
                        if (!sat[k]) m_cnt[k] = maxc[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
        #1;
        chk("model_count0", count0, m_cnt[0]);
        chk("model_limit0", limit0, m_lim[0]);
        chk("model_count1", count1, m_cnt[1]);
        chk("model_limit1", limit1, m_lim[1]);
    end

    task automatic press(input bit u, input bit d);
        @(negedge clk); push_up = u; push_down = d;
        @(negedge clk); push_up = 1'b0; push_down = 1'b0;
    endtask

    task automatic load_val(input int v);
        @(negedge clk); load = 1'b1; lv = 4'(v);
        @(negedge clk); load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_count0", count0, 0);
        chk("reset_limit0", limit0, 0);
        chk("reset_count1", count1, 0);
        rst_n = 1'b1;
        @(negedge clk);
`ifndef COUNTER_DEBOUNCE_EN
        for (int i = 1; i <= 4; i++) begin
            press(1'b1, 1'b0);
            chk("wrap_count0", count0, i % 4);
            chk("wrap_limit0", limit0, int'(i == 4));
            chk("up_count1", count1, i);
        end
        load_val(9);
        chk("load9_count1", count1, 9);
        chk("load9_count0", count0, 1);
        press(1'b1, 1'b0);
        chk("sat_up_count1", count1, 9);
        chk("sat_up_limit1", limit1, 1);
        for (int i = 1; i <= 10; i++) begin
            press(1'b0, 1'b1);
            chk("down_count1", count1, (i < 9) ? 9 - i : 0);
            chk("down_limit1", limit1, int'(i == 10));
        end
        load_val(5);
        press(1'b1, 1'b1);
        chk("both_count1", count1, 5);
        chk("both_limit1", limit1, 0);
        chk("both_count0", count0, 1);
        @(negedge clk); load = 1'b1; lv = 4'd12; push_up = 1'b1;
        @(negedge clk); load = 1'b0; push_up = 1'b0;
        chk("clamp_count1", count1, 9);
        chk("clamp_count0", count0, 0);
        chk("clamp_limit1", limit1, 0);
        // Async reset with push_up held high through release.
        @(negedge clk); push_up = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_count1", count1, 0);
        chk("async_rst_limit1", limit1, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_count0", count0, 0);
        chk("held_count1", count1, 0);
        push_up = 1'b0;
        press(1'b1, 1'b0);
        chk("repress_count0", count0, 1);
        chk("repress_count1", count1, 1);
`else
        @(negedge clk); push_up = 1'b1;
        repeat (3) @(negedge clk);
        push_up = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_count0", count0, 0);
        chk("glitch_count1", count1, 0);
        push_up = 1'b1;
        repeat (4) @(negedge clk);
        chk("db_edge4_count1", count1, 0);
        @(negedge clk);
        chk("db_edge5_count1", count1, 1);
        chk("db_edge5_count0", count0, 1);
        chk("db_edge5_limit0", limit0, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_count1", count1, 0);
        chk("async_rst_count0", count0, 0);
        @(negedge clk); push_up = 1'b0; rst_n = 1'b1;
        repeat (2 * DB) @(negedge clk);
`endif
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
`ifdef COUNTER_DEBOUNCE_EN
            if ($urandom_range(0, 5) == 0) push_up = ~push_up;
            if ($urandom_range(0, 5) == 0) push_down = ~push_down;
`else
            if ($urandom_range(0, 2) == 0) push_up = ~push_up;
            if ($urandom_range(0, 2) == 0) push_down = ~push_down;
`endif
            load  = ($urandom_range(0, 15) == 0);
            lv    = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk); rst_n = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
